// File: rtl/full_adder_pkg.sv
// -----------------------------------------------------------------------------
// full_adder_pkg
//   Bit-level arithmetic helpers shared by the full_adder slice.
//   fa_sum   : sum bit of a 1-bit full adder (a ^ b ^ c).
//   fa_carry : carry out of a 1-bit full adder, written as generate/propagate
//              so the carry term reads as "generate, or propagate the input".
// -----------------------------------------------------------------------------
package full_adder_pkg;

  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    // generate (a & b) or propagate the incoming carry when a ^ b
    return (a & b) | (c & (a ^ b));
  endfunction

endpackage : full_adder_pkg

// File: rtl/full_adder_cell.sv
// -----------------------------------------------------------------------------
// fa_cell
//   Purely combinational 1-bit full adder, one link of the ripple chain.
//   Ports:
//     a, b : operand bits
//     ci   : carry in from the previous (less significant) cell
//     s    : sum bit
//     co   : carry out to the next (more significant) cell
// -----------------------------------------------------------------------------
module fa_cell
  import full_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = fa_sum(a, b, ci);
  assign co = fa_carry(a, b, ci);

endmodule : fa_cell

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   Registered ripple-carry adder of WIDTH bits built from fa_cell instances.
//   {Cout, S} <= X1 + X2 + Cin on every rising clk where in_valid is high;
//   S and Cout hold otherwise. out_valid pulses for each new result.
//   Parameters:
//     WIDTH     : operand / sum width, 1..64
//   Ports:
//     clk       : clock, rising edge
//     rst_n     : asynchronous active-low reset
//     X1, X2    : unsigned operands
//     Cin       : carry into bit 0
//     in_valid  : qualifies X1/X2/Cin for capture this edge
//     S         : registered sum
//     Cout      : registered carry out of bit WIDTH-1
//     out_valid : high for one cycle per captured input
// -----------------------------------------------------------------------------
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] X1,
  input  logic [WIDTH-1:0] X2,
  input  logic             Cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             out_valid
);

  // carry_chain[i] is the carry into cell i; carry_chain[WIDTH] is the final carry.
  logic [WIDTH:0]   carry_chain;
  logic [WIDTH-1:0] sum_next;

  logic [WIDTH-1:0] s_reg;
  logic             cout_reg;
  logic             out_valid_reg;

  assign carry_chain[0] = Cin;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      fa_cell u_cell (
        .a  (X1[gi]),
        .b  (X2[gi]),
        .ci (carry_chain[gi]),
        .s  (sum_next[gi]),
        .co (carry_chain[gi+1])
      );
    end
  endgenerate

  // Result registers; a reset discards any in-flight result immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_reg         <= '0;
      cout_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= in_valid;
      if (in_valid) begin
        s_reg    <= sum_next;
        cout_reg <= carry_chain[WIDTH];
      end
    end
  end

  assign S         = s_reg;
  assign Cout      = cout_reg;
  assign out_valid = out_valid_reg;

endmodule : full_adder

// File: tb/tb_full_adder.sv
// -----------------------------------------------------------------------------
// tb_full_adder
//   Three instances (WIDTH 1, 4, 8) share clk and rst_n. Expected results
//   come from plain integer addition and are queued when an input is
//   captured; per-instance monitors pop and compare on the falling edge.
// -----------------------------------------------------------------------------
module tb_full_adder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  // WIDTH = 1
  logic [0:0] a1 = '0, b1 = '0, s1;
  logic       c1 = 1'b0, v1 = 1'b0, co1, ov1;
  // WIDTH = 4
  logic [3:0] a4 = '0, b4 = '0, s4;
  logic       c4 = 1'b0, v4 = 1'b0, co4, ov4;
  // WIDTH = 8
  logic [7:0] a8 = '0, b8 = '0, s8;
  logic       c8 = 1'b0, v8 = 1'b0, co8, ov8;

  full_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .X1(a1), .X2(b1), .Cin(c1), .in_valid(v1),
    .S(s1), .Cout(co1), .out_valid(ov1)
  );
  full_adder #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .X1(a4), .X2(b4), .Cin(c4), .in_valid(v4),
    .S(s4), .Cout(co4), .out_valid(ov4)
  );
  full_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .X1(a8), .X2(b8), .Cin(c8), .in_valid(v8),
    .S(s8), .Cout(co8), .out_valid(ov8)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard queues and last-result images (what S/Cout should hold).
  logic [64:0] q1[$], q4[$], q8[$];
  logic [64:0] held1 = '0, held4 = '0, held8 = '0;

  // Reference model: unsigned sum at full precision, pushed at capture.
  always @(posedge clk) begin
    if (rst_n) begin
      if (v1) q1.push_back(65'(a1) + 65'(b1) + 65'(c1));
      if (v4) q4.push_back(65'(a4) + 65'(b4) + 65'(c4));
      if (v8) q8.push_back(65'(a8) + 65'(b8) + 65'(c8));
    end
  end

  // Reset drops in-flight results and the held outputs go back to zero.
  always @(negedge rst_n) begin
    q1.delete(); q4.delete(); q8.delete();
    held1 = '0; held4 = '0; held8 = '0;
  end

  // Monitors
  always @(negedge clk) begin
    if (rst_n) begin
      if (ov1) begin
        if (q1.size() == 0) check("w1_spurious_valid", 65'(ov1), 65'(0));
        else begin
          held1 = q1.pop_front();
          $display("[w1] cout_s=%0h exp=%0h", {co1, s1}, held1);
          check("w1_result", 65'({co1, s1}), held1);
        end
      end else begin
        check("w1_hold", 65'({co1, s1}), held1);
        if (q1.size() != 0) begin
          check("w1_missing_valid", 65'(ov1), 65'(1));
          void'(q1.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (ov4) begin
        if (q4.size() == 0) check("w4_spurious_valid", 65'(ov4), 65'(0));
        else begin
          held4 = q4.pop_front();
          $display("[w4] cout_s=%0h exp=%0h", {co4, s4}, held4);
          check("w4_result", 65'({co4, s4}), held4);
        end
      end else begin
        check("w4_hold", 65'({co4, s4}), held4);
        if (q4.size() != 0) begin
          check("w4_missing_valid", 65'(ov4), 65'(1));
          void'(q4.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (ov8) begin
        if (q8.size() == 0) check("w8_spurious_valid", 65'(ov8), 65'(0));
        else begin
          held8 = q8.pop_front();
          $display("[w8] cout_s=%0h exp=%0h", {co8, s8}, held8);
          check("w8_result", 65'({co8, s8}), held8);
        end
      end else begin
        check("w8_hold", 65'({co8, s8}), held8);
        if (q8.size() != 0) begin
          check("w8_missing_valid", 65'(ov8), 65'(1));
          void'(q8.pop_front());
        end
      end
    end
  end

  // Stimulus: inputs change 1 time unit after the rising edge.
  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_w1", 65'({ov1, co1, s1}), 65'(0));
    check("rst_w4", 65'({ov4, co4, s4}), 65'(0));
    check("rst_w8", 65'({ov8, co8, s8}), 65'(0));
    @(negedge clk);
    #1 rst_n = 1'b1;

    // WIDTH=1 exhaustive, back-to-back
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      a1 = 1'(i >> 2); b1 = 1'(i >> 1); c1 = 1'(i); v1 = 1'b1;
    end
    @(posedge clk);
    #1 v1 = 1'b0;
    #1 check("w1_before_reset", 65'({co1, s1}), 65'(3));

    // Async reset between edges while output shows {Cout,S}=11
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_w1", 65'({ov1, co1, s1}), 65'(0));
    check("async_rst_w4", 65'({ov4, co4, s4}), 65'(0));
    check("async_rst_w8", 65'({ov8, co8, s8}), 65'(0));

    // Release and first capture: 0 + 1 + 1 -> S=0, Cout=1
    @(negedge clk);
    #1 rst_n = 1'b1;
    a1 = 1'b0; b1 = 1'b1; c1 = 1'b1; v1 = 1'b1;
    @(posedge clk);
    #1 v1 = 1'b0;
    check("release_w1", 65'({ov1, co1, s1}), 65'(3'b110));

    // WIDTH=4 full carry propagation
    @(posedge clk);
    #1 a4 = 4'hF; b4 = 4'h0; c4 = 1'b1; v4 = 1'b1;
    @(posedge clk);
    #1 a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
    @(posedge clk);
    #1 v4 = 1'b0;

    // Hold: capture 1+0+0, then idle with all-ones inputs
    @(posedge clk);
    #1 a1 = 1'b1; b1 = 1'b0; c1 = 1'b0; v1 = 1'b1;
    @(posedge clk);
    #1 a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; v1 = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("hold_w1", 65'({ov1, co1, s1}), 65'(3'b001));

    // WIDTH=8 random, continuous valid
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom); v8 = 1'b1;
    end
    // WIDTH=8 random with gaps in valid
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      v8 = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk);
    #1 v8 = 1'b0;

    repeat (4) @(posedge clk);
    #1;
    check("drain_w1", 65'(q1.size()), 65'(0));
    check("drain_w4", 65'(q4.size()), 65'(0));
    check("drain_w8", 65'(q8.size()), 65'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_full_adder
